// File: rtl/rdout_pkg.sv
// Shared types for the image readout controller: FSM states, core status codes,
// the FIFO entry (pixel plus line/frame tags) and a width helper.
package rdout_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROCESS,
    S_READOUT,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_HOLD    = 2'b10;
  localparam logic [1:0] ST_PROCESS = 2'b01;
  localparam logic [1:0] ST_READ    = 2'b00;

  // Widest pixel the FIFO entry can carry; narrower pixels occupy the low bits.
  localparam int PIX_W_MAX = 16;

  typedef struct packed {
    logic [PIX_W_MAX-1:0] data;
    logic                 eol;
    logic                 last;
  } ent_t;

  // Bits needed to hold the value n (at least one).
  function automatic int bits_for(input longint unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rdout_fifo.sv
// Show-ahead synchronous FIFO of tagged pixels; head is visible while not empty.
// Write lands at the clock edge; writes while full are dropped, so the caller meters them with count.
module rdout_fifo
  import rdout_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  ent_t             wr_dat,
  input  logic             rd_en,
  output ent_t             rd_dat,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W    = bits_for(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  ent_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty  = (count == '0);
  assign do_wr  = wr_en && (count != CNT_W'(DEPTH));
  assign do_rd  = rd_en && !empty;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

endmodule

// File: rtl/image_readout_ctrl.sv
// Runs the core, then streams its image in raster order; RDOUT_CHECKSUM_EN adds a pixel checksum port.
// First pixel valid MEM_LAT+1 cycles after its address; pix_ready low stalls address issue via FIFO credit.
module image_readout_ctrl
  import rdout_pkg::*;
#(
  parameter int IMG_W       = 256,
  parameter int IMG_H       = 256,
  parameter int PIX_W       = 8,
  parameter int ADDR_W      = 16,
  parameter int MEM_LAT     = 1,
  parameter int TIMEOUT_CYC = 34152256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              end_process,
  output logic [1:0]        status_o,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_eol,
  output logic              pix_last,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef RDOUT_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int DEPTH = MEM_LAT + 2;
  localparam int CNT_W = bits_for(DEPTH);
  localparam int WD_W  = bits_for(TIMEOUT_CYC);
  localparam int COL_W = bits_for(IMG_W - 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT_CYC);

  if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_chk_addr
    $error("IMG_W*IMG_H does not fit in ADDR_W address bits");
  end
  if (MEM_LAT < 1) begin : g_chk_lat
    $error("MEM_LAT must be at least 1");
  end
  if (PIX_W > PIX_W_MAX) begin : g_chk_pix
    $error("PIX_W exceeds the FIFO entry data width");
  end

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  addr;
  logic [COL_W-1:0]   col;
  logic [WD_W-1:0]    wd;
  logic [CNT_W-1:0]   out_cnt;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [MEM_LAT-1:0] pv;
  logic [MEM_LAT-1:0] peol;
  logic [MEM_LAT-1:0] plast;
  logic               fifo_empty;
  logic               start_ok;
  logic               timeout;
  logic               issue;
  logic               wr;
  logic               pop;
  logic               drained;
  logic [CNT_W:0]     credit_used;
  ent_t               wr_ent;
  ent_t               head;
  logic               unused_hi;

  assign start_ok    = (state == S_IDLE) && start;
  assign timeout     = (wd >= WD_LIMIT);
  assign credit_used = (CNT_W+1)'(out_cnt) + (CNT_W+1)'(fifo_cnt);
  assign issue       = (state == S_READOUT) && (credit_used < (CNT_W+1)'(DEPTH));
  assign wr          = pv[MEM_LAT-1];
  assign pop         = pix_valid && pix_ready;
  // Nothing in flight and the FIFO empties at this edge.
  assign drained     = (out_cnt == '0) && (fifo_cnt == CNT_W'(pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    status_o  = ST_HOLD;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_PROCESS;
      end
      S_PROCESS: begin
        status_o = ST_PROCESS;
        if (end_process)  state_nxt = S_READOUT;
        else if (timeout) state_nxt = S_DONE;
      end
      S_READOUT: begin
        status_o = ST_READ;
        if (issue && (addr == LAST_ADDR)) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        status_o = ST_READ;
        if (drained) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      col  <= '0;
      wd   <= '0;
      err  <= 1'b0;
    end else begin
      if (start_ok) begin
        addr <= '0;
        col  <= '0;
        wd   <= '0;
        err  <= 1'b0;
      end
      if (state == S_PROCESS) begin
        if (!timeout) wd <= wd + WD_W'(1);
        if (!end_process && timeout) err <= 1'b1;
      end
      if (issue) begin
        addr <= addr + ADDR_W'(1);
        col  <= (col == LAST_COL) ? '0 : col + COL_W'(1);
      end
    end
  end

  assign mem_addr = addr;

  // Read-return pipeline: one valid bit plus tags per cycle of memory latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv      <= '0;
      peol    <= '0;
      plast   <= '0;
      out_cnt <= '0;
    end else begin
      pv      <= (pv << 1) | MEM_LAT'(issue);
      peol    <= (peol << 1) | MEM_LAT'(col == LAST_COL);
      plast   <= (plast << 1) | MEM_LAT'(addr == LAST_ADDR);
      out_cnt <= out_cnt + CNT_W'(issue) - CNT_W'(wr);
    end
  end

  assign wr_ent = '{data: PIX_W_MAX'(mem_rdata), eol: peol[MEM_LAT-1], last: plast[MEM_LAT-1]};

  rdout_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr),
    .wr_dat (wr_ent),
    .rd_en  (pop),
    .rd_dat (head),
    .empty  (fifo_empty),
    .count  (fifo_cnt)
  );

  // Head storage is unreset, so gate it to keep the stream outputs at zero when empty.
  assign pix_valid = !fifo_empty;
  assign pix_data  = fifo_empty ? '0 : head.data[PIX_W-1:0];
  assign pix_eol   = !fifo_empty && head.eol;
  assign pix_last  = !fifo_empty && head.last;
  assign unused_hi = ^(head.data >> PIX_W);

`ifdef RDOUT_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (start_ok) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + 16'(pix_data);
    end
  end
`endif

endmodule

// File: doc/image_readout_ctrl.md
# image_readout_ctrl

Parametrised frame controller between the `cpu` core and the image consumer. It starts a processing run and waits for `end_process`, with a cycle-count watchdog. It then reads the result image out of the core's memory in raster order and streams it as a valid/ready pixel stream with line and frame markers. Memory read latency is absorbed by a small credit-controlled FIFO, so backpressure never loses or duplicates pixels.

## Interface
- `IMG_W`, 256, pixels per line
- `IMG_H`, 256, lines per frame; `IMG_W*IMG_H` ≤ 2^`ADDR_W` (elaboration-time check)
- `PIX_W`, 8, pixel width
- `ADDR_W`, 16, memory address width
- `MEM_LAT`, 1, memory read latency in cycles (≥1)
- `TIMEOUT_CYC`, 34152256, maximum PROCESS cycles before abort
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle request; ignored unless IDLE
- `end_process`  in  1  core finished, level
- `status_o`  out  2  core mode: 2'b10 HOLD, 2'b01 PROCESS, 2'b00 READ
- `mem_addr`  out  `ADDR_W`  read address to core
- `mem_rdata`  in  `PIX_W`  read data, valid `MEM_LAT` cycles after address
- `pix_data`  out  `PIX_W`  output pixel
- `pix_valid` / `pix_ready`  out / in  1  stream handshake; transfer when both high
- `pix_eol`  out  1  pixel is last of its line
- `pix_last`  out  1  pixel is last of frame
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at run end
- `err`  out  1  timeout flag; held until next accepted `start`

## Operation
- FSM states: IDLE → PROCESS → READOUT → FLUSH → DONE → IDLE.
- IDLE
  - `status_o`=HOLD.
  - `start` moves to PROCESS; clears `err`, the watchdog, and the address/column counters.
- PROCESS
  - `status_o`=PROCESS; watchdog increments each cycle.
  - `end_process` sampled high moves to READOUT.
  - Watchdog reaching `TIMEOUT_CYC` without `end_process` sets `err` and moves to DONE; no readout occurs.
  - If both happen in the same cycle, `end_process` wins.
- READOUT
  - `status_o`=READ.
  - An address is issued, and the linear address incremented, only when outstanding reads plus FIFO occupancy < FIFO depth (`MEM_LAT`+2).
  - A column counter tags each read with eol/last; the tags travel with the data through the FIFO.
  - The cycle after address `IMG_W*IMG_H-1` is issued, the FSM moves to FLUSH.
- FLUSH: `status_o`=READ; waits until outstanding reads = 0 and the FIFO is empty.
- DONE: `done`=1 for one cycle, then IDLE.
- Stream: `pix_valid` = FIFO not empty; data and tags are held stable while `pix_valid && !pix_ready`.

## Timing
- Reset values:
  - `status_o`=2'b10, `mem_addr`=0.
  - `pix_valid`, `pix_eol`, `pix_last`, `busy`, `done`, `err` all 0.
  - FIFO empty, FSM in IDLE.
- `start` in cycle T: `busy`=1 and `status_o`=PROCESS from T+1.
- `end_process` high in cycle P: `status_o`=READ and `mem_addr`=0 in P+1.
- Address issued in cycle A: data is captured into the FIFO at the end of A+`MEM_LAT`; `pix_valid` goes high at A+`MEM_LAT`+1.
- With `pix_ready` held high, sustained throughput is one pixel per cycle.
- `done` pulses the cycle after the last transfer, or the cycle after the watchdog expiry.
- `rst_n` low mid-run: immediate return to reset values; FIFO and in-flight reads are discarded.

## Configuration
- `RDOUT_CHECKSUM_EN` defined:
  - Adds output `checksum` [15:0], the sum mod 2^16 of all transferred pixels.
  - Cleared on accepted `start`; stable from `done` until the next `start`; reset value 0.
- Undefined: port and adder absent; all other behaviour identical.

## Structure
- Package `rdout_pkg`: FSM state enum, status codes (`ST_HOLD`, `ST_PROCESS`, `ST_READ`), FIFO tag struct {data, eol, last}.
- Sub-module `rdout_fifo`: synchronous FIFO, depth `MEM_LAT`+2, show-ahead output, count output used for credit.

## Test plan
- Reset check: assert `rst_n`=0 → `status_o`=2'b10, all other outputs 0, `mem_addr`=0.
- Nominal frame:
  - Setup: `IMG_W`=`IMG_H`=4, `MEM_LAT`=1, mem[a]=a^8'hA5, `pix_ready`=1, `end_process` 10 cycles after start.
  - Response: 16 pixels A5,A4,… in order; eol on pixels 3/7/11/15; last on 15; `done` one cycle later.
- Backpressure: `MEM_LAT`=3, `pix_ready` low for 5 cycles mid-line, then random → exact 16-pixel sequence, `mem_addr` stalls, FIFO never exceeds 5 entries.
- Timeout: `TIMEOUT_CYC`=20, `end_process` never asserted → `err`=1, `done` 21 cycles after PROCESS entry, no `pix_valid`.
- Reset mid-readout after 7 transfers → outputs return to reset values at once; a new `start` yields a full frame from address 0.
- With `RDOUT_CHECKSUM_EN`: mem[a]=a+1 on a 4x4 frame → `checksum`=136 at `done`.
